sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 7, number of sprite requesters (index 0 = player, 1-5 = enemies, 6 = boss).
REQ-002 SHALL have parameter ADDR_W, default 12, sprite ROM address width.
REQ-003 SHALL have parameter DATA_W, default 8, ROM pixel width (RGB 3-3-2).
REQ-004 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles; legal range 1-3.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port req, input, NREQ, per-requester read request level.
REQ-008 SHALL have port addr, input, NREQ*ADDR_W, flattened per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port en_mask, input, NREQ, requester enable; a 0 bit makes that requester ineligible (boss hidden).
REQ-010 SHALL have port prio0, input, 1, when 1 requester 0 wins over round-robin order.
REQ-011 SHALL have port gnt, output, NREQ, registered one-hot grant pulse.
REQ-012 SHALL have port rom_en, output, 1, ROM read enable.
REQ-013 SHALL have port rom_addr, output, ADDR_W, ROM address.
REQ-014 SHALL have port rom_data, input, DATA_W, ROM read data, valid ROM_LAT cycles after rom_en.
REQ-015 SHALL have port rd_valid, output, 1, returned pixel valid.
REQ-016 SHALL have port rd_id, output, 3, requester index of the returned pixel.
REQ-017 SHALL have port rd_data, output, DATA_W, returned pixel.
REQ-018 SHALL have port rd_transp, output, 1, 1 when rd_data equals 8'hFF (transparent key).

Function
REQ-019 SHALL arbitrate every cycle over eligible = req AND en_mask AND NOT gnt (a requester granted this cycle is excluded).
REQ-020 SHALL, if prio0=1 and eligible[0]=1, select requester 0; otherwise SHALL select the first eligible index at or after pointer ptr, wrapping NREQ-1 to 0.
REQ-021 SHALL register the selection: in the next cycle gnt has exactly that one bit set, rom_en=1, rom_addr = the winner's addr slice as sampled in the arbitration cycle.
REQ-022 SHALL, with no eligible requester, drive gnt=0, rom_en=0 and hold rom_addr.
REQ-023 SHALL update ptr to (winner+1) mod NREQ on every grant, including prio0 grants; ptr unchanged when no grant.
REQ-024 SHALL carry rom_en and winner index through a ROM_LAT-deep valid/id shift pipeline; rd_valid, rd_id, rd_data, rd_transp are registered and appear ROM_LAT+1 cycles after the gnt cycle.
REQ-025 SHALL hold rd_id and rd_data when rd_valid=0.
REQ-026 SHALL allow requesters to drop req before grant with no grant issued; requester holding req continuously is granted at most every second cycle.
REQ-027 SHALL guarantee, with prio0=0, that any continuously eligible requester is granted within NREQ grants.
REQ-028 SHALL treat en_mask cleared mid-request as immediate ineligibility; grants and reads already issued still complete.

Reset
REQ-029 SHALL, on rst=0 at a clk edge, set gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_id=0, rd_data=0, rd_transp=0, ptr=0 and clear the pipeline.
REQ-030 SHALL discard in-flight reads on reset mid-operation; no rd_valid pulse may follow reset for a pre-reset grant.

Structure
REQ-031 SHALL take the transparent key 8'hFF and requester index constants (PLAYER=0, BOSS=6) from the shared sprite package.
REQ-032 SHALL contain one sub-module, rr_pick, the combinational rotate-priority selector (eligible vector, ptr -> one-hot winner plus index).

Verification
REQ-033 Reset: rst=0 for 3 cycles with req=7'h7F -> gnt=0, rd_valid=0 throughout; first gnt=7'h01 the cycle after release.
REQ-034 Round-robin: req=7'h7F, en_mask=7'h7F, prio0=0 -> gnt sequence 01,02,04,08,10,20,40,01; rd_id follows 0..6 with ROM_LAT+1 offset.
REQ-035 Priority: ptr=3, req=7'h09, prio0=1 -> gnt=7'h01 then 7'h08; next ptr=4.
REQ-036 Mask: req=7'h40, en_mask=7'h3F -> no gnt, rom_en=0 for 20 cycles; set en_mask bit 6 -> gnt=7'h40 next cycle.
REQ-037 Latency/data: ROM_LAT=2, grant requester 2 with addr 12'h123, ROM model returns 8'hFF -> rd_valid 3 cycles after gnt, rd_id=2, rd_data=8'hFF, rd_transp=1.
REQ-038 Reset mid-flight: rst=0 the cycle after gnt=7'h04 -> no subsequent rd_valid.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// rtl/sprite_rom_arbiter_pkg.sv - shared sprite constants for the ROM arbiter
package sprite_rom_arbiter_pkg;

  localparam int              ID_W       = 3;
  localparam logic [7:0]      TRANSP_KEY = 8'hFF;
  localparam logic [ID_W-1:0] PLAYER     = 3'd0;
  localparam logic [ID_W-1:0] BOSS       = 3'd6;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rtl/sprite_rom_arbiter_rr_pick.sv - rotate-priority selector: first eligible index at or after ptr
module rr_pick
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ = 7
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [ID_W-1:0] win_idx,
  output logic            win_any
);

  logic [ID_W:0] cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    cand       = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!win_any && eligible[cand[ID_W-1:0]]) begin
        win_any                       = 1'b1;
        win_idx                       = cand[ID_W-1:0];
        win_onehot[cand[ID_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM arbiter with player priority and read-return pipeline
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ    = 7,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ-1:0]          en_mask,
  input  logic                     prio0,
  output logic [NREQ-1:0]          gnt,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     rd_valid,
  output logic [2:0]               rd_id,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_transp
);

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gidx_q, gidx_d;
  logic [ROM_LAT-1:0] vpipe_q, vpipe_d;
  logic [ID_W-1:0]   ipipe_q [ROM_LAT];
  logic [ID_W-1:0]   ipipe_d [ROM_LAT];
  logic              rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_transp_q, rd_transp_d;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   rr_onehot, win_onehot;
  logic [ID_W-1:0]   rr_idx, win_idx;
  logic              rr_any, win_any;
  logic [ADDR_W-1:0] sel_addr;

  // The current grant holder is masked out, so a steady requester gets every other cycle.
  assign eligible = req & en_mask & ~gnt_q;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .eligible   (eligible),
    .ptr        (ptr_q),
    .win_onehot (rr_onehot),
    .win_idx    (rr_idx),
    .win_any    (rr_any)
  );

  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    win_any    = rr_any;
    if (prio0 && eligible[PLAYER]) begin
      win_onehot         = '0;
      win_onehot[PLAYER] = 1'b1;
      win_idx            = PLAYER;
      win_any            = 1'b1;
    end
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) sel_addr = addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    gnt_d      = win_onehot;
    rom_en_d   = win_any;
    rom_addr_d = win_any ? sel_addr : rom_addr_q;
    gidx_d     = win_any ? win_idx : gidx_q;
    ptr_d      = ptr_q;
    if (win_any) begin
      ptr_d = (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
    // Stage 0 lines up with the cycle the ROM sees rom_en; the last stage with rom_data.
    vpipe_d[0] = rom_en_q;
    ipipe_d[0] = gidx_q;
    for (int k = 1; k < ROM_LAT; k++) begin
      vpipe_d[k] = vpipe_q[k-1];
      ipipe_d[k] = ipipe_q[k-1];
    end
    rd_valid_d  = vpipe_q[ROM_LAT-1];
    rd_id_d     = rd_valid_d ? ipipe_q[ROM_LAT-1] : rd_id_q;
    rd_data_d   = rd_valid_d ? rom_data : rd_data_q;
    rd_transp_d = rd_valid_d ? (rom_data == DATA_W'(TRANSP_KEY)) : rd_transp_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      ptr_q       <= '0;
      gidx_q      <= '0;
      vpipe_q     <= '0;
      for (int k = 0; k < ROM_LAT; k++) ipipe_q[k] <= '0;
      rd_valid_q  <= 1'b0;
      rd_id_q     <= '0;
      rd_data_q   <= '0;
      rd_transp_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      vpipe_q     <= vpipe_d;
      ipipe_q     <= ipipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_id_q     <= rd_id_d;
      rd_data_q   <= rd_data_d;
      rd_transp_q <= rd_transp_d;
    end
  end

  assign gnt       = gnt_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_id     = rd_id_q;
  assign rd_data   = rd_data_q;
  assign rd_transp = rd_transp_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed vector bench for sprite_rom_arbiter (ROM_LAT=2)
module tb_sprite_rom_arbiter;

  localparam int NREQ = 7;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int ROM_LAT = 2;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ-1:0]        en_mask;
  logic                   prio0;
  logic [NREQ-1:0]        gnt;
  logic                   rom_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic                   rd_valid;
  logic [2:0]             rd_id;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_transp;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .en_mask(en_mask), .prio0(prio0),
    .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .rd_transp(rd_transp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] slice_addr(input int i);
    return 12'h101 + 12'(i) * 12'h011;
  endfunction

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    if (a == 12'h123) return 8'hFF;
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int oh_idx(input logic [6:0] oh);
    int r = 0;
    for (int i = 0; i < 7; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // two-cycle registered ROM
  logic [7:0] r1, r2;
  always @(posedge clk) begin
    if (rom_en) r1 <= rom_f(rom_addr);
    r2 <= r1;
  end
  assign rom_data = r2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", nm, row, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [6:0] req;
    logic [6:0] en;
    logic       prio0;
    logic [6:0] gnt;
    logic       rdv;
    logic [2:0] rid;
  } vec_t;

  vec_t tbl [25];

  initial begin
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_tr;
    int          n;

    tbl[0]  = '{1'b0, 7'h7F, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 7'h7F, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 7'h7F, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h01, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h02, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h04, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h08, 1'b1, 3'd0};
    tbl[7]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h10, 1'b1, 3'd1};
    tbl[8]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h20, 1'b1, 3'd2};
    tbl[9]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h40, 1'b1, 3'd3};
    tbl[10] = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h01, 1'b1, 3'd4};
    tbl[11] = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h02, 1'b1, 3'd5};
    tbl[12] = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h04, 1'b1, 3'd6};
    tbl[13] = '{1'b1, 7'h09, 7'h7F, 1'b1, 7'h01, 1'b1, 3'd0};
    tbl[14] = '{1'b1, 7'h09, 7'h7F, 1'b1, 7'h08, 1'b1, 3'd1};
    tbl[15] = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h10, 1'b1, 3'd2};
    tbl[16] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd0};
    tbl[17] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd3};
    tbl[18] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd4};
    tbl[19] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd4};
    tbl[20] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd4};
    tbl[21] = '{1'b1, 7'h01, 7'h7F, 1'b0, 7'h01, 1'b0, 3'd4};
    tbl[22] = '{1'b1, 7'h01, 7'h7F, 1'b0, 7'h00, 1'b0, 3'd4};
    tbl[23] = '{1'b1, 7'h01, 7'h7F, 1'b0, 7'h01, 1'b0, 3'd4};
    tbl[24] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd0};

    for (int i = 0; i < NREQ; i++) addr[i*ADDR_W +: ADDR_W] = slice_addr(i);
    exp_addr = '0;
    exp_data = '0;
    exp_tr   = 1'b0;

    for (int r = 0; r < 25; r++) begin
      rst     = tbl[r].rst;
      req     = tbl[r].req;
      en_mask = tbl[r].en;
      prio0   = tbl[r].prio0;
      step();
      if (!tbl[r].rst) begin
        exp_addr = '0;
        exp_data = '0;
        exp_tr   = 1'b0;
      end else begin
        if (tbl[r].gnt != 0) exp_addr = slice_addr(oh_idx(tbl[r].gnt));
        if (tbl[r].rdv) begin
          exp_data = rom_f(slice_addr(int'(tbl[r].rid)));
          exp_tr   = (exp_data == 8'hFF);
        end
      end
      chk("gnt", r, 32'(gnt), 32'(tbl[r].gnt));
      chk("rom_en", r, 32'(rom_en), 32'(tbl[r].gnt != 0));
      chk("rom_addr", r, 32'(rom_addr), 32'(exp_addr));
      chk("rd_valid", r, 32'(rd_valid), 32'(tbl[r].rdv));
      chk("rd_id", r, 32'(rd_id), 32'(tbl[r].rid));
      chk("rd_data", r, 32'(rd_data), 32'(exp_data));
      chk("rd_transp", r, 32'(rd_transp), 32'(exp_tr));
    end

    // boss hidden by en_mask, then revealed
    req = 7'h40;
    en_mask = 7'h3F;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("mask_gnt", c, 32'(gnt), 32'h0);
      chk("mask_rom_en", c, 32'(rom_en), 32'h0);
    end
    chk("mask_addr_hold", 0, 32'(rom_addr), 32'(slice_addr(0)));
    en_mask = 7'h7F;
    step();
    chk("unmask_gnt", 0, 32'(gnt), 32'h40);
    chk("unmask_addr", 0, 32'(rom_addr), 32'(slice_addr(6)));
    req = 7'h00;
    for (int c = 0; c < 5; c++) step();

    // read latency and transparent key
    req = 7'h04;
    step();
    chk("lat_gnt", 0, 32'(gnt), 32'h04);
    chk("lat_addr", 0, 32'(rom_addr), 32'h123);
    req = 7'h00;
    n = 0;
    while (n < 8) begin
      step();
      n++;
      if (rd_valid) break;
    end
    chk("lat_cycles", 0, 32'(n), 32'd3);
    chk("lat_rd_id", 0, 32'(rd_id), 32'd2);
    chk("lat_rd_data", 0, 32'(rd_data), 32'hFF);
    chk("lat_transp", 0, 32'(rd_transp), 32'h1);
    step();
    chk("lat_single", 0, 32'(rd_valid), 32'h0);

    // reset right after a grant discards the read
    for (int c = 0; c < 3; c++) step();
    req = 7'h04;
    step();
    chk("mid_gnt", 0, 32'(gnt), 32'h04);
    rst = 1'b0;
    req = 7'h00;
    step();
    chk("mid_rst_gnt", 0, 32'(gnt), 32'h0);
    chk("mid_rst_rdv", 0, 32'(rd_valid), 32'h0);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_no_rdv", c, 32'(rd_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
